// File: rtl/rop3_pkg.sv
// rop3_pkg: shared state encoding and ROP3 canonical mode constants
package rop3_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, DONE, ERROR} state_t;
  localparam int MODE_W = 8;
  localparam logic [MODE_W-1:0] ROP_P = 8'hF0;
  localparam logic [MODE_W-1:0] ROP_S = 8'hCC;
  localparam logic [MODE_W-1:0] ROP_D = 8'hAA;
endpackage

// File: rtl/rop3_obs_merge.sv
// rop3_obs_merge: folds one P/S/D/Result observation into the known Mode bits
module rop3_obs_merge
  import rop3_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [N-1:0]      p,
  input  logic [N-1:0]      s,
  input  logic [N-1:0]      d,
  input  logic [N-1:0]      r,
  input  logic [MODE_W-1:0] mask,
  input  logic [MODE_W-1:0] mode,
  output logic [MODE_W-1:0] next_mask,
  output logic [MODE_W-1:0] next_mode,
  output logic              conflict
);
  logic [MODE_W-1:0] hit1, hit0;
  // per truth-table index: did any bit propose a 1, did any bit propose a 0
  always_comb begin
    hit1 = '0;
    hit0 = '0;
    for (int i = 0; i < N; i++)
      if (r[i]) hit1[{p[i], s[i], d[i]}] = 1'b1;
      else      hit0[{p[i], s[i], d[i]}] = 1'b1;
  end
  assign next_mask = mask | hit1 | hit0;
  assign next_mode = (mode & ~hit0) | hit1;
  assign conflict  = |(hit1 & hit0) | |(mask & ((hit1 & ~mode) | (hit0 & mode)));
endmodule

// File: rtl/rop3_mode_finder.sv
// rop3_mode_finder: reconstructs the ROP3 Mode truth table from observed samples
module rop3_mode_finder
  import rop3_pkg::*;
#(
  parameter int N           = 5,
  parameter int MAX_SAMPLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      P,
  input  logic [N-1:0]      S,
  input  logic [N-1:0]      D,
  input  logic [N-1:0]      Result,
  output logic [MODE_W-1:0] Mode_out,
  output logic [MODE_W-1:0] known_mask,
  output logic              mode_valid,
  output logic              conflict,
  output logic              done,
  output logic [6:0]        sample_cnt
);
  localparam logic [6:0] MAX_CNT = 7'(MAX_SAMPLES);
  state_t            state;
  logic [MODE_W-1:0] nmask, nmode;
  logic              mconf, accept;
  logic [6:0]        cnt_nxt;
  rop3_obs_merge #(.N(N)) u_merge (
    .p(P), .s(S), .d(D), .r(Result),
    .mask(known_mask), .mode(Mode_out),
    .next_mask(nmask), .next_mode(nmode), .conflict(mconf)
  );
  assign in_ready   = state == COLLECT;
  assign done       = state == DONE || state == ERROR;
  assign conflict   = state == ERROR;
  assign mode_valid = state == DONE && known_mask == 8'hFF;
  assign accept     = in_valid && in_ready;
  assign cnt_nxt    = sample_cnt == MAX_CNT ? sample_cnt : sample_cnt + 7'd1;
  // collection FSM; a conflicting sample is counted but leaves Mode/mask untouched
  always_ff @(posedge clk)
    if (rst) begin
      state      <= IDLE;
      Mode_out   <= '0;
      known_mask <= '0;
      sample_cnt <= '0;
    end else if (start) begin
      state      <= COLLECT;
      Mode_out   <= '0;
      known_mask <= '0;
      sample_cnt <= '0;
    end else if (accept) begin
      sample_cnt <= cnt_nxt;
      if (mconf) state <= ERROR;
      else begin
        Mode_out   <= nmode;
        known_mask <= nmask;
        state      <= (nmask == 8'hFF || cnt_nxt == MAX_CNT) ? DONE : COLLECT;
      end
    end
endmodule

// File: tb/tb_rop3_mode_finder.sv
// tb_rop3_mode_finder: table-driven check of Mode reconstruction, conflicts and handshake
module tb_rop3_mode_finder;
  import rop3_pkg::*;
  logic clk = 0, rst = 1, start = 0, in_valid = 0;
  logic [4:0] P = '0, S = '0, D = '0, Result = '0;
  logic in_ready, mode_valid, conflict, done;
  logic [7:0] Mode_out, known_mask;
  logic [6:0] sample_cnt;
  int checks = 0, passed = 0;
  always #5 clk = ~clk;
  rop3_mode_finder #(.N(5), .MAX_SAMPLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .P(P), .S(S), .D(D), .Result(Result), .Mode_out(Mode_out), .known_mask(known_mask),
    .mode_valid(mode_valid), .conflict(conflict), .done(done), .sample_cnt(sample_cnt)
  );
  typedef struct {
    logic st, v;
    logic [4:0] p, s, d, r;
    logic ir;
    logic [7:0] m, mo;
    logic [6:0] c;
    logic dn, mv, cf;
  } vec_t;
  vec_t tv[16];
  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
  endtask
  task automatic check_all(input int idx, input logic ir, input logic [7:0] m, input logic [7:0] mo,
                           input logic [6:0] c, input logic dn, input logic mv, input logic cf);
    chk("in_ready", idx, {7'd0, in_ready}, {7'd0, ir});
    chk("known_mask", idx, known_mask, m);
    chk("Mode_out", idx, Mode_out, mo);
    chk("sample_cnt", idx, {1'b0, sample_cnt}, {1'b0, c});
    chk("done", idx, {7'd0, done}, {7'd0, dn});
    chk("mode_valid", idx, {7'd0, mode_valid}, {7'd0, mv});
    chk("conflict", idx, {7'd0, conflict}, {7'd0, cf});
  endtask
  task automatic drive(input logic st, input logic v, input logic [4:0] p, input logic [4:0] s,
                       input logic [4:0] d, input logic [4:0] r);
    @(negedge clk);
    start = st; in_valid = v; P = p; S = s; D = d; Result = r;
    @(posedge clk);
    #1;
  endtask
  localparam logic [4:0] AP = 5'b10000, AS = 5'b01100, AD = 5'b01010, AR = 5'b10110;
  localparam logic [4:0] BP = 5'b11110, BS = 5'b11001, BD = 5'b10101, BR = 5'b10010;
  initial begin
    //            st v  P   S   D   R          ir mask   mode   cnt  dn mv cf
    tv[0]  = '{1, 0, 0,  0,  0,  0,          1, 8'h00, 8'h00, 0,  0, 0, 0};
    tv[1]  = '{0, 1, AP, AS, AD, AR,         1, 8'h1F, 8'h16, 1,  0, 0, 0};
    tv[2]  = '{0, 1, BP, BS, BD, BR,         0, 8'hFF, 8'h96, 2,  1, 1, 0};
    tv[3]  = '{0, 1, AP, AS, AD, AR,         0, 8'hFF, 8'h96, 2,  1, 1, 0};
    tv[4]  = '{1, 1, AP, AS, AD, AR,         1, 8'h00, 8'h00, 0,  0, 0, 0};
    tv[5]  = '{0, 1, AP, AS, AD, AR,         1, 8'h1F, 8'h16, 1,  0, 0, 0};
    tv[6]  = '{0, 1, AP, AS, AD, 5'b10111,   0, 8'h1F, 8'h16, 2,  1, 0, 1};
    tv[7]  = '{1, 0, 0,  0,  0,  0,          1, 8'h00, 8'h00, 0,  0, 0, 0};
    tv[8]  = '{0, 1, 0,  0,  0,  5'b00001,   0, 8'h00, 8'h00, 1,  1, 0, 1};
    tv[9]  = '{1, 0, 0,  0,  0,  0,          1, 8'h00, 8'h00, 0,  0, 0, 0};
    tv[10] = '{0, 1, 0,  0,  0,  0,          1, 8'h01, 8'h00, 1,  0, 0, 0};
    tv[11] = '{0, 1, 0,  0,  0,  0,          1, 8'h01, 8'h00, 2,  0, 0, 0};
    tv[12] = '{0, 1, 0,  0,  0,  0,          1, 8'h01, 8'h00, 3,  0, 0, 0};
    tv[13] = '{0, 1, 0,  0,  0,  0,          0, 8'h01, 8'h00, 4,  1, 0, 0};
    tv[14] = '{0, 1, 0,  0,  0,  0,          0, 8'h01, 8'h00, 4,  1, 0, 0};
    tv[15] = '{1, 0, 0,  0,  0,  0,          1, 8'h00, 8'h00, 0,  0, 0, 0};
    repeat (2) @(posedge clk);
    #1;
    check_all(100, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    rst = 0;
    drive(0, 1, AP, AS, AD, AR);
    drive(0, 1, AP, AS, AD, AR);
    check_all(101, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      drive(tv[i].st, tv[i].v, tv[i].p, tv[i].s, tv[i].d, tv[i].r);
      check_all(i, tv[i].ir, tv[i].m, tv[i].mo, tv[i].c, tv[i].dn, tv[i].mv, tv[i].cf);
    end
    drive(0, 1, AP, AS, AD, AR);
    check_all(102, 1, 8'h1F, 8'h16, 1, 0, 0, 0);
    @(negedge clk);
    rst = 1;
    start = 1;
    @(posedge clk);
    #1;
    check_all(103, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 0;
    start = 0;
    drive(0, 1, BP, BS, BD, BR);
    drive(0, 1, BP, BS, BD, BR);
    check_all(104, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 5'b11111, 5'b11111, 5'b11111, 5'b00000);
    check_all(105, 1, 8'h81, 8'h00, 2, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/rop3_mode_finder.md
Name: rop3_mode_finder

Overview:
- Inverse of the ROP3 datapath. It observes a stream of (P, S, D, Result) samples produced by an unknown ROP3 unit and reconstructs the 8-bit Mode truth table from them.
- Used as a self-check and debug monitor beside rop3_smart and rop3_lut256.
- It flags inconsistent observations and reports when the Mode is fully determined.

Parameters:
- N, 5, operand width; must match the observed ROP3 unit.
- MAX_SAMPLES, 64, samples accepted before an incomplete finish; must be at least 1.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; clears all accumulated state and begins collection
- in_valid  in  1  sample present on P/S/D/Result
- in_ready  out  1  block accepts a sample this cycle
- P  in  N  pattern operand of the sample
- S  in  N  source operand of the sample
- D  in  N  destination operand of the sample
- Result  in  N  ROP3 output for this P/S/D
- Mode_out  out  8  reconstructed Mode; bits not yet known read 0
- known_mask  out  8  bit k=1 means Mode bit k has been determined
- mode_valid  out  1  Mode fully determined, with no conflict
- conflict  out  1  observations are inconsistent with any single Mode
- done  out  1  collection finished (DONE or ERROR state)
- sample_cnt  out  7  number of accepted samples, saturating at MAX_SAMPLES

Behaviour:
- ROP3 rule: for each bit i, idx = {P[i], S[i], D[i]} with P as MSB, and Result[i] = Mode[idx]. Canonical checks: 0xF0 is P, 0xCC is S, 0xAA is D.
- Reset (rst=1 at a clock edge): state goes to IDLE. All outputs are 0, including in_ready, Mode_out, known_mask, sample_cnt and every flag. rst has priority over start and over any sample.
- States: IDLE, COLLECT, DONE, ERROR.
- IDLE: in_ready=0 and samples are ignored. On start, clear all accumulators and go to COLLECT.
- COLLECT: in_ready=1. A sample is accepted when in_valid && in_ready.
- On acceptance, each bit i proposes Mode[idx_i] = Result[i]. The new known_mask is the old mask OR the set of all proposed idx values; proposed values are merged into Mode_out.
- A conflict occurs if:
  - two bits within one sample propose different values for the same idx, or
  - a proposal differs from an already-known bit.
- Priority of next state after an accepted sample, evaluated on the updated values:
  - any conflict goes to ERROR;
  - otherwise a full known_mask (8'hFF) goes to DONE;
  - otherwise sample_cnt reaching MAX_SAMPLES goes to DONE.
- Latency: all outputs are registered and update at the acceptance edge. done, mode_valid and conflict are visible in the cycle after the accepting cycle.
- DONE: done=1 and in_ready=0. mode_valid=1 only if known_mask==8'hFF; an incomplete finish leaves mode_valid=0 with a partial known_mask.
- ERROR: done=1, conflict=1, mode_valid=0, in_ready=0. Mode_out and known_mask hold their pre-conflict values.
- start in any state (including mid-COLLECT) clears the accumulators, sample_cnt and flags, and enters COLLECT. A sample presented in the same cycle as start is not accepted.
- sample_cnt never wraps; it saturates at MAX_SAMPLES.
- No combinational path from in_valid to in_ready; in_ready is a function of state only.

Decomposition:
- Package rop3_pkg holds:
  - a state enum (IDLE, COLLECT, DONE, ERROR);
  - MODE_W=8;
  - the constants ROP_P=8'hF0, ROP_S=8'hCC, ROP_D=8'hAA, shared with the ROP3 units and the bench.
- One purely combinational sub-module, rop3_obs_merge. It takes one sample plus the current mask/mode and produces the next mask, the next mode and a conflict bit. The FSM, counter and registers stay in rop3_mode_finder.

Test Plan:
1. Mode 0x96, N=5:
   - start, then sample A: P=10000, S=01100, D=01010, Result=10110. Expect known_mask=0x1F.
   - Then sample B: P=11110, S=11001, D=10101, Result=10010. Expect done=1, mode_valid=1, Mode_out=0x96, sample_cnt=2, conflict=0.
2. Cross-sample conflict: start, send sample A, then A again with Result=10111. Expect ERROR: conflict=1, done=1, mode_valid=0, known_mask stays 0x1F.
3. Intra-sample conflict: start, send P=S=D=00000 with Result=00001. Expect conflict=1, done=1 the next cycle.
4. Incomplete finish: MAX_SAMPLES=4, send four samples with P=S=D=00000, Result=00000. Expect done=1, mode_valid=0, known_mask=0x01, Mode_out=0x00, sample_cnt=4.
5. Reset mid-collection: after sample A, assert rst for 1 cycle. Expect all outputs 0 and in_ready=0. A later in_valid without start is ignored (sample_cnt stays 0).
6. Handshake and restart:
   - in_valid held high in IDLE and DONE: no acceptance, sample_cnt unchanged.
   - start in DONE: known_mask=0 and in_ready=1 the next cycle.
   - start with a coincident in_valid: sample_cnt=0.
